apb_spi_master_fifo: RTL and testbench
======================================

# apb_spi_master_fifo

APB-programmable SPI master, the parametrised successor to the single-byte APB-SPI controller. It adds configurable frame width, TX/RX FIFOs, multiple active-low slave selects, and all four CPOL/CPHA modes. It also provides back-to-back frames with SS held low, plus overrun detection. It sits on the peripheral APB segment and drives off-chip SPI slaves directly.

## Interface
- DATA_W, 8: SPI frame width and APB data width (8 or 16)
- FIFO_DEPTH, 4: entries per TX and RX FIFO (power of two, ≥2)
- NUM_SS, 2: number of slave-select outputs (1–8)
- PCLK input 1: sole clock; all logic on rising edge
- PRESET_n input 1: asynchronous, active-low reset
- PSEL_i, PENABLE_i, PWRITE_i input 1: APB control
- PADDR_i input 3: register address
- PWDATA_i input DATA_W: write data
- PRDATA_o output DATA_W: read data, valid when PREADY_o=1
- PREADY_o output 1: `PSEL_i & PENABLE_i` (zero wait state)
- PSLVERR_o output 1: error flag, valid with PREADY_o
- miso_i input 1: serial in
- mosi_o output 1: serial out
- sclk_o output 1: serial clock
- ss_o output NUM_SS: active-low slave selects, at most one low
- spi_interrupt_request_o output 1: level interrupt

## Operation
- Register map, by address. Unused bits read 0.
  - 0 CR: [0]SPE, [1]CPOL, [2]CPHA, [3]LSBFE, [4]TXEIE, [5]RXNEIE, [6]OVRIE.
  - 1 SSR: [2:0] target slave index; an index ≥ NUM_SS selects none.
  - 2 BR: [7:0] divider; SCLK half-period = BR+1 PCLK cycles.
  - 3 SR: [0]TXE, [1]TXF, [2]RXNE, [3]RXF, [4]BUSY, [5]OVR. Writing 1 to bit 5 clears OVR; other bits are read-only.
  - 4 DR: a write pushes the TX FIFO; a read pops the RX FIFO.
- PSLVERR_o=1, with no state change, on:
  - addresses 5–7;
  - a DR write while TXF=1;
  - a DR read while RXNE=0 (PRDATA_o=0).
- Register writes and FIFO push/pop commit on the access-phase edge (PSEL_i & PENABLE_i & PREADY_o).
- Engine FSM:
  - IDLE: sclk_o=CPOL, all ss_o high. If SPE=1 and TXE=0, pop the TX word, latch CPOL/CPHA/LSBFE/BR/SSR, drive the selected ss_o low, go to SETUP.
  - SETUP: wait BR+1 cycles, then go to SHIFT.
  - SHIFT: 2·DATA_W SCLK edges, one every BR+1 cycles.
    - CPHA=0: the first bit is on mosi_o from SETUP entry. Sample miso_i on leading edges; shift on trailing edges.
    - CPHA=1: shift on leading edges; sample on trailing edges.
    - Bit order is MSB-first unless LSBFE=1.
    - After the last edge go to HOLD.
  - HOLD: wait BR+1 cycles, then push the RX word. If RXF=1, drop the word and set OVR.
    - If SPE=1 and TXE=0: pop the next word and go to SETUP with ss_o held low. Mode/BR/SSR are re-latched; if SSR changed, ss_o deasserts for 1 cycle first.
    - Otherwise: raise all ss_o and go to IDLE.
- Register changes during a frame take effect only at the next frame latch.
- Clearing SPE in any non-IDLE state:
  - aborts immediately: ss_o high, sclk_o=CPOL, state IDLE;
  - discards the in-flight frame;
  - flushes both FIFOs.
- BUSY=1 in every state except IDLE.
- spi_interrupt_request_o = (TXEIE&TXE) | (RXNEIE&RXNE) | (OVRIE&OVR), registered.
- Simultaneous APB pop and engine push on the RX FIFO (or APB push and engine pop on TX) are both honoured. Count is unchanged, and a full FIFO stays non-overflowed.

## Timing
- Reset values:
  - ss_o all 1, sclk_o=0, mosi_o=0;
  - PRDATA_o=0, PSLVERR_o=0, spi_interrupt_request_o=0;
  - CR=0, SSR=0, BR=0, OVR=0;
  - FIFOs empty, FSM IDLE.
- Reset asserted mid-frame returns everything to these values asynchronously.
- PRDATA_o is combinational from the address (FIFO head for DR).
- DR write to ss_o low: 1 cycle when idle.
- Frame duration, ss low to word in RX FIFO: (2·DATA_W+2)·(BR+1) cycles.
- Back-to-back frames with an unchanged SSR have no ss_o high gap.
- Status flags are registered and update the cycle after the FIFO change.
- A W1C clear of OVR coinciding with a new overrun leaves OVR=1.

## Test plan
- **Mode 0, single frame.** DATA_W=8, BR=1, CR=0x01, SSR=0; DR write 0xA5; slave returns 0x3C.
  - Expect: mosi bits 1,0,1,0,0,1,0,1; ss_o=2'b10 for 36 cycles.
  - Expect: DR read=0x3C, RXNE then 0.
- **All four modes.** CPOL/CPHA 00/01/10/11 with 0x96 looped miso=mosi.
  - Expect: RX=0x96 in each mode; sclk_o idle level equals CPOL.
- **Burst with overrun.** Four DR writes 0x01..0x04 with FIFO_DEPTH=4, no reads.
  - Expect: ss_o stays low across all four frames; RXF=1 after 4; a fifth word sets OVR.
  - Expect: OVRIE interrupt fires; W1C clears OVR.
- **APB errors.**
  - Fifth DR write with TX full: PSLVERR=1, FIFO unchanged.
  - DR read when empty: PSLVERR=1, PRDATA=0.
  - PADDR=6: PSLVERR=1.
- **Abort.** Clear SPE at the 3rd SCLK edge.
  - Expect: ss_o high and sclk_o=CPOL the next cycle; TXE=1, RXNE=0, BUSY=0.
- **Async reset mid-frame.** PRESET_n low mid-SHIFT.
  - Expect: all outputs at reset values immediately, without waiting for a clock edge.
  - Expect: new frame after release behaves as in the single-frame scenario.

Source files
------------

// File: rtl/apb_spi_master_fifo.sv
// APB-programmable SPI master with TX/RX FIFOs, selectable CPOL/CPHA/bit order,
// multiple active-low slave selects, back-to-back frames and RX overrun flag.
module apb_spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              PSEL_i,
  input  logic              PENABLE_i,
  input  logic              PWRITE_i,
  input  logic [2:0]        PADDR_i,
  input  logic [DATA_W-1:0] PWDATA_i,
  output logic [DATA_W-1:0] PRDATA_o,
  output logic              PREADY_o,
  output logic              PSLVERR_o,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic [NUM_SS-1:0] ss_o,
  output logic              spi_interrupt_request_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state;
  logic [6:0]        cr;            // {OVRIE,RXNEIE,TXEIE,LSBFE,CPHA,CPOL,SPE}
  logic [2:0]        ssr, l_ssr;
  logic [7:0]        br, l_br, cnt;
  logic              ovr, l_cpol, l_cpha, l_lsbfe;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]       tx_cnt, rx_cnt;

  logic tx_empty, tx_full, rx_empty, rx_full, busy;
  logic access, err, wr_ok, rd_ok, apb_push, apb_pop, abort;
  logic tick, last_edge, eng_pop, eng_push, rx_push_ok, ovr_set, ovr_clr;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (AW+1)'(FIFO_DEPTH));
  assign busy     = (state != S_IDLE);
  assign tx_head  = tx_mem[tx_rp];

  // APB decode: zero wait state, errors suppress every side effect.
  assign access    = PSEL_i & PENABLE_i;
  assign PREADY_o  = access;
  assign err       = (PADDR_i >= 3'd5)
                   | ((PADDR_i == 3'd4) & PWRITE_i & tx_full)
                   | ((PADDR_i == 3'd4) & ~PWRITE_i & rx_empty);
  assign PSLVERR_o = access & err;
  assign wr_ok     = access & PWRITE_i & ~err;
  assign rd_ok     = access & ~PWRITE_i & ~err;
  assign apb_push  = wr_ok & (PADDR_i == 3'd4);
  assign apb_pop   = rd_ok & (PADDR_i == 3'd4);
  assign ovr_clr   = wr_ok & (PADDR_i == 3'd3) & PWDATA_i[5];
  assign abort     = wr_ok & (PADDR_i == 3'd0) & ~PWDATA_i[0] & busy;

  assign tick       = (cnt == l_br);
  assign last_edge  = (edge_cnt == EW'(2 * DATA_W - 1));
  assign eng_pop    = ~abort & cr[0] & ~tx_empty &
                      ((state == S_IDLE) | ((state == S_HOLD) & tick));
  assign eng_push   = ~abort & (state == S_HOLD) & tick;
  assign rx_push_ok = eng_push & (~rx_full | apb_pop);
  assign ovr_set    = eng_push & rx_full & ~apb_pop;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    PRDATA_o = '0;
    case (PADDR_i)
      3'd0:    PRDATA_o[6:0] = cr;
      3'd1:    PRDATA_o[2:0] = ssr;
      3'd2:    PRDATA_o[7:0] = br;
      3'd3:    PRDATA_o[5:0] = {ovr, busy, rx_full, ~rx_empty, tx_full, tx_empty};
      3'd4:    if (!rx_empty) PRDATA_o = rx_mem[rx_rp];
      default: PRDATA_o = '0;
    endcase
  end

  function automatic logic [NUM_SS-1:0] ss_dec(input logic [2:0] idx);
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (idx == 3'(i)) ss_dec[i] = 1'b0;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      cr  <= '0;
      ssr <= '0;
      br  <= '0;
      ovr <= 1'b0;
      spi_interrupt_request_o <= 1'b0;
    end else begin
      if (wr_ok && PADDR_i == 3'd0) cr  <= PWDATA_i[6:0];
      if (wr_ok && PADDR_i == 3'd1) ssr <= PWDATA_i[2:0];
      if (wr_ok && PADDR_i == 3'd2) br  <= PWDATA_i[7:0];
      ovr <= ovr_set | (ovr & ~ovr_clr);
      spi_interrupt_request_o <= (cr[4] & tx_empty) | (cr[5] & ~rx_empty) | (cr[6] & ovr);
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (abort) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (apb_push)   tx_wp <= tx_wp + 1'b1;
      if (eng_pop)    tx_rp <= tx_rp + 1'b1;
      if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
      if (apb_pop)    rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(apb_push) - (AW+1)'(eng_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push_ok) - (AW+1)'(apb_pop);
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and counts alone define validity.
  always_ff @(posedge PCLK) begin
    if (apb_push)   tx_mem[tx_wp] <= PWDATA_i;
    if (rx_push_ok) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= S_IDLE;
      ss_o <= '1; sclk_o <= 1'b0; mosi_o <= 1'b0;
      cnt <= '0; edge_cnt <= '0; tx_sh <= '0; rx_sh <= '0;
      l_cpol <= 1'b0; l_cpha <= 1'b0; l_lsbfe <= 1'b0; l_br <= '0; l_ssr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sclk_o <= cr[1];
          ss_o   <= '1;
          if (eng_pop) begin
            ss_o  <= ss_dec(ssr);
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else cnt <= cnt + 8'd1;
        end
        S_SHIFT: begin
          if (tick) begin
            cnt      <= '0;
            sclk_o   <= ~sclk_o;
            edge_cnt <= edge_cnt + 1'b1;
            // Even edge index is the leading edge; CPHA picks sample vs. shift role.
            if (~edge_cnt[0] ^ l_cpha)
              rx_sh <= l_lsbfe ? {miso_i, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso_i};
            else begin
              mosi_o <= l_lsbfe ? tx_sh[0] : tx_sh[DATA_W-1];
              tx_sh  <= l_lsbfe ? (tx_sh >> 1) : (tx_sh << 1);
            end
            if (last_edge) state <= S_HOLD;
          end else cnt <= cnt + 8'd1;
        end
        S_HOLD: begin
          if (tick) begin
            if (eng_pop) begin
              if (ssr != l_ssr) begin
                ss_o  <= '1;
                state <= S_GAP;
              end else begin
                ss_o  <= ss_dec(ssr);
                state <= S_SETUP;
              end
            end else begin
              ss_o   <= '1;
              sclk_o <= l_cpol;
              state  <= S_IDLE;
            end
          end else cnt <= cnt + 8'd1;
        end
        S_GAP: begin
          ss_o  <= ss_dec(l_ssr);
          cnt   <= '0;
          state <= S_SETUP;
        end
        default: state <= S_IDLE;
      endcase

      // Frame latch: mode, divider and target are frozen here for the whole frame.
      if (eng_pop) begin
        l_cpol   <= cr[1];
        l_cpha   <= cr[2];
        l_lsbfe  <= cr[3];
        l_br     <= br;
        l_ssr    <= ssr;
        sclk_o   <= cr[1];
        cnt      <= '0;
        edge_cnt <= '0;
        mosi_o   <= cr[3] ? tx_head[0] : tx_head[DATA_W-1];
        tx_sh    <= cr[2] ? tx_head : (cr[3] ? (tx_head >> 1) : (tx_head << 1));
      end

      if (abort) begin
        state  <= S_IDLE;
        ss_o   <= '1;
        sclk_o <= PWDATA_i[1];
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_master_fifo.sv
// Directed bench for apb_spi_master_fifo: single frame, all modes, burst/overrun,
// APB errors, abort and asynchronous reset mid-frame.
module tb_apb_spi_master_fifo;

  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic       PSEL_i = 1'b0, PENABLE_i = 1'b0, PWRITE_i = 1'b0;
  logic [2:0] PADDR_i = '0;
  logic [7:0] PWDATA_i = '0;
  logic [7:0] PRDATA_o;
  logic       PREADY_o, PSLVERR_o;
  logic       miso_i, mosi_o, sclk_o;
  logic [1:0] ss_o;
  logic       spi_interrupt_request_o;

  apb_spi_master_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_SS(2)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL_i(PSEL_i), .PENABLE_i(PENABLE_i), .PWRITE_i(PWRITE_i),
    .PADDR_i(PADDR_i), .PWDATA_i(PWDATA_i),
    .PRDATA_o(PRDATA_o), .PREADY_o(PREADY_o), .PSLVERR_o(PSLVERR_o),
    .miso_i(miso_i), .mosi_o(mosi_o), .sclk_o(sclk_o), .ss_o(ss_o),
    .spi_interrupt_request_o(spi_interrupt_request_o)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Slave model: either loopback, or a mode-0 slave returning slave_pat MSB-first.
  logic       loopback = 1'b1;
  logic [7:0] slave_pat = '0;
  int         slave_idx = 0;
  logic       cap_en = 1'b0;
  int         cap_n = 0;
  logic [7:0] cap_byte = '0;
  logic       mon = 1'b0;
  int         fall_cnt = 0;
  wire        ss_any_low = ~&ss_o;

  always @(posedge ss_any_low) begin
    slave_idx = 0;
    if (mon) fall_cnt++;
  end
  always @(negedge sclk_o) if (ss_any_low) slave_idx++;
  always @(posedge sclk_o) begin
    if (cap_en && cap_n < 8) begin
      cap_byte[3'(7 - cap_n)] = mosi_o;
      cap_n++;
    end
  end
  always_comb begin
    if (loopback)           miso_i = mosi_o;
    else if (slave_idx < 8) miso_i = slave_pat[3'(7 - slave_idx)];
    else                    miso_i = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic perr);
    @(negedge PCLK);
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = wr; PADDR_i = addr; PWDATA_i = wdata;
    @(negedge PCLK);
    PENABLE_i = 1'b1;
    #1;
    rdata = PRDATA_o;
    perr  = PSLVERR_o;
    @(negedge PCLK);
    PSEL_i = 1'b0; PENABLE_i = 1'b0; PWRITE_i = 1'b0;
  endtask

  task automatic apb_wr(input logic [2:0] addr, input logic [7:0] wdata);
    logic [7:0] d;
    logic e;
    apb_xfer(1'b1, addr, wdata, d, e);
  endtask

  task automatic apb_rd(input logic [2:0] addr, output logic [7:0] d, output logic e);
    apb_xfer(1'b0, addr, 8'h00, d, e);
  endtask

  task automatic wait_sclk_edges(input int n, output int seen);
    logic prev;
    prev = sclk_o;
    seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge PCLK);
      if (sclk_o !== prev) begin
        seen++;
        prev = sclk_o;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic e;
    total++;
    if (ss_o !== 2'b11 || sclk_o !== 1'b0 || mosi_o !== 1'b0) begin
      bad++; $display("FAIL reset_pins: ss=%b sclk=%b mosi=%b, want ss=11 sclk=0 mosi=0", ss_o, sclk_o, mosi_o);
    end
    total++;
    if (PRDATA_o !== 8'h00 || PSLVERR_o !== 1'b0 || spi_interrupt_request_o !== 1'b0) begin
      bad++; $display("FAIL reset_apb: prdata=%h pslverr=%b irq=%b, want 00 0 0", PRDATA_o, PSLVERR_o, spi_interrupt_request_o);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h01 || e !== 1'b0) begin
      bad++; $display("FAIL reset_sr: got %h err=%b, want 01 err=0", d, e);
    end
  endtask

  task automatic run_single_frame(input string tag);
    logic [7:0] d;
    logic e;
    int lowc;
    loopback = 1'b0;
    slave_pat = 8'h3C;
    apb_wr(3'd2, 8'd1);
    apb_wr(3'd1, 8'd0);
    apb_wr(3'd0, 8'h01);
    cap_n = 0;
    cap_en = 1'b1;
    apb_wr(3'd4, 8'hA5);
    for (int i = 0; i < 10 && ss_o !== 2'b10; i++) @(negedge PCLK);
    lowc = 0;
    while (ss_o === 2'b10 && lowc < 200) begin
      lowc++;
      @(negedge PCLK);
    end
    cap_en = 1'b0;
    total++;
    if (lowc != 36) begin
      bad++; $display("FAIL %s ss_low_cycles: got %0d, want 36", tag, lowc);
    end
    total++;
    if (cap_n != 8 || cap_byte !== 8'hA5) begin
      bad++; $display("FAIL %s mosi_bits: got %h (%0d bits), want a5 (8 bits)", tag, cap_byte, cap_n);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h05) begin
      bad++; $display("FAIL %s sr_after_frame: got %h, want 05", tag, d);
    end
    apb_rd(3'd4, d, e);
    total++;
    if (d !== 8'h3C || e !== 1'b0) begin
      bad++; $display("FAIL %s dr_read: got %h err=%b, want 3c err=0", tag, d, e);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h01 || spi_interrupt_request_o !== 1'b0) begin
      bad++; $display("FAIL %s sr_after_pop: got %h irq=%b, want 01 irq=0", tag, d, spi_interrupt_request_o);
    end
  endtask

  task automatic test_mode0();
    run_single_frame("mode0");
  endtask

  task automatic test_modes();
    logic [7:0] d;
    logic e;
    logic cpol, cpha;
    loopback = 1'b1;
    apb_wr(3'd2, 8'd0);
    for (int m = 0; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      apb_wr(3'd0, {5'b0, cpha, cpol, 1'b1});
      repeat (2) @(negedge PCLK);
      total++;
      if (sclk_o !== cpol) begin
        bad++; $display("FAIL mode%0d idle_sclk: got %b, want %b", m, sclk_o, cpol);
      end
      apb_wr(3'd4, 8'h96);
      repeat (30) @(negedge PCLK);
      total++;
      if (sclk_o !== cpol) begin
        bad++; $display("FAIL mode%0d post_sclk: got %b, want %b", m, sclk_o, cpol);
      end
      apb_rd(3'd4, d, e);
      total++;
      if (d !== 8'h96 || e !== 1'b0) begin
        bad++; $display("FAIL mode%0d rx: got %h err=%b, want 96 err=0", m, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic e;
    loopback = 1'b1;
    apb_wr(3'd2, 8'd0);
    apb_wr(3'd0, 8'h41);
    fall_cnt = 0;
    mon = 1'b1;
    for (int i = 1; i <= 4; i++) apb_wr(3'd4, 8'(i));
    repeat (100) @(negedge PCLK);
    total++;
    if (fall_cnt != 1) begin
      bad++; $display("FAIL burst_ss_falls: got %0d, want 1", fall_cnt);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h0D || spi_interrupt_request_o !== 1'b0) begin
      bad++; $display("FAIL burst_sr_full: got %h irq=%b, want 0d irq=0", d, spi_interrupt_request_o);
    end
    apb_wr(3'd4, 8'h05);
    repeat (30) @(negedge PCLK);
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h2D || spi_interrupt_request_o !== 1'b1) begin
      bad++; $display("FAIL burst_overrun: got %h irq=%b, want 2d irq=1", d, spi_interrupt_request_o);
    end
    apb_wr(3'd3, 8'h20);
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h0D || spi_interrupt_request_o !== 1'b0) begin
      bad++; $display("FAIL burst_w1c: got %h irq=%b, want 0d irq=0", d, spi_interrupt_request_o);
    end
    for (int i = 1; i <= 4; i++) begin
      apb_rd(3'd4, d, e);
      total++;
      if (d !== 8'(i) || e !== 1'b0) begin
        bad++; $display("FAIL burst_rx%0d: got %h err=%b, want %h err=0", i, d, e, 8'(i));
      end
    end
    mon = 1'b0;
    apb_wr(3'd0, 8'h01);
  endtask

  task automatic test_apb_errors();
    logic [7:0] d;
    logic e, errs;
    apb_wr(3'd0, 8'h00);
    errs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 3'd4, 8'h11 + 8'(i), d, e);
      errs |= e;
    end
    total++;
    if (errs !== 1'b0) begin
      bad++; $display("FAIL err_fill: got pslverr=%b on fill, want 0", errs);
    end
    apb_xfer(1'b1, 3'd4, 8'h15, d, e);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL err_tx_full: got pslverr=%b, want 1", e);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h02) begin
      bad++; $display("FAIL err_sr_txf: got %h, want 02", d);
    end
    apb_rd(3'd6, d, e);
    total++;
    if (e !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL err_addr6: got err=%b data=%h, want err=1 data=00", e, d);
    end
    apb_xfer(1'b1, 3'd5, 8'hFF, d, e);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL err_addr5: got err=%b, want 1", e);
    end
    apb_rd(3'd4, d, e);
    total++;
    if (e !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL err_rx_empty: got err=%b data=%h, want err=1 data=00", e, d);
    end
    loopback = 1'b1;
    apb_wr(3'd2, 8'd0);
    apb_wr(3'd0, 8'h01);
    repeat (120) @(negedge PCLK);
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h0D) begin
      bad++; $display("FAIL err_drain_sr: got %h, want 0d", d);
    end
    for (int i = 0; i < 4; i++) begin
      apb_rd(3'd4, d, e);
      total++;
      if (d !== 8'h11 + 8'(i)) begin
        bad++; $display("FAIL err_fifo_word%0d: got %h, want %h", i, d, 8'h11 + 8'(i));
      end
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL err_final_sr: got %h, want 01", d);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic e;
    int seen;
    loopback = 1'b1;
    apb_wr(3'd2, 8'd3);
    apb_wr(3'd0, 8'h01);
    apb_wr(3'd4, 8'h5A);
    apb_wr(3'd4, 8'h6B);
    wait_sclk_edges(3, seen);
    total++;
    if (seen != 3 || sclk_o !== 1'b1) begin
      bad++; $display("FAIL abort_edges: got %0d edges sclk=%b, want 3 sclk=1", seen, sclk_o);
    end
    apb_wr(3'd0, 8'h00);
    total++;
    if (ss_o !== 2'b11 || sclk_o !== 1'b0) begin
      bad++; $display("FAIL abort_pins: got ss=%b sclk=%b, want 11 0", ss_o, sclk_o);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL abort_sr: got %h, want 01", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic e;
    int seen;
    loopback = 1'b0;
    slave_pat = 8'h3C;
    apb_wr(3'd2, 8'd1);
    apb_wr(3'd0, 8'h01);
    apb_wr(3'd4, 8'hFF);
    wait_sclk_edges(3, seen);
    #2;
    PRESET_n = 1'b0;
    #1;
    total++;
    if (ss_o !== 2'b11 || sclk_o !== 1'b0 || mosi_o !== 1'b0 || spi_interrupt_request_o !== 1'b0) begin
      bad++; $display("FAIL async_reset: got ss=%b sclk=%b mosi=%b irq=%b, want 11 0 0 0",
                      ss_o, sclk_o, mosi_o, spi_interrupt_request_o);
    end
    @(negedge PCLK);
    PRESET_n = 1'b1;
    apb_rd(3'd0, d, e);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL reset_cr: got %h, want 00", d);
    end
    apb_rd(3'd3, d, e);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL reset_sr_mid: got %h, want 01", d);
    end
    run_single_frame("after_reset");
  endtask

  initial begin
    PRESET_n = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    test_reset();
    PRESET_n = 1'b1;
    test_mode0();
    test_modes();
    test_back_to_back();
    test_apb_errors();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
